// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Shares the single-ported data memory between instruction fetch and
// load/store, with LS lane selection, data alignment and error detection.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_LIMIT = 1024,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic [31:0] mem_addy,
   output logic [31:0] mem_datain,
   output logic        mem_wen,
   output logic        mem_ren,
   output logic [3:0]  mem_byte_selector,
   input  logic [31:0] mem_dataout
);

   localparam int          CW       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
   localparam logic [31:0] LIMIT_W  = 32'(ADDR_LIMIT);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          owner_ls_q, owner_ls_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [1:0]    off_q, off_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic          if_gnt_q, if_gnt_d;
   logic          ls_gnt_q, ls_gnt_d;
   logic          wen_q, wen_d;
   logic          ren_q, ren_d;
   logic [3:0]    bsel_q, bsel_d;
   logic [31:0]   addy_q, addy_d;
   logic [31:0]   din_q, din_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic          ls_rvalid_q, ls_rvalid_d;
   logic [31:0]   ls_rdata_q, ls_rdata_d;
   logic          ls_err_q, ls_err_d;

   logic          if_win;
   logic          ls_misal, ls_oor, ls_bad;
   logic [3:0]    ls_bsel;
   logic [31:0]   ls_repl;
   logic [31:0]   ld_shift, ld_ext;
   logic          if_addr_unused;

   assign if_addr_unused = ^if_addr[1:0];
   assign if_win = if_req && (!ls_req || (cnt_q == CNT_MAX));

   // LS request decode, evaluated against the live inputs at arbitration.
   always_comb begin
      ls_misal = 1'b0;
      ls_bsel  = 4'h0;
      ls_repl  = ls_wdata;
      case (ls_size)
         2'd0: begin
            ls_bsel = 4'b0001 << ls_addr[1:0];
            ls_repl = {4{ls_wdata[7:0]}};
         end
         2'd1: begin
            ls_misal = ls_addr[0];
            ls_bsel  = 4'b0011 << ls_addr[1:0];
            ls_repl  = {2{ls_wdata[15:0]}};
         end
         2'd2: begin
            ls_misal = |ls_addr[1:0];
            ls_bsel  = 4'hF;
         end
         default: ls_misal = 1'b1;
      endcase
      ls_oor = {2'b00, ls_addr[31:2]} >= LIMIT_W;
      ls_bad = ls_misal || ls_oor;
   end

   always_comb begin
      ld_shift = mem_dataout >> {off_q, 3'b000};
      ld_ext   = mem_dataout;
      case (size_q)
         2'd0: ld_ext = uns_q ? {24'h0, ld_shift[7:0]}  : {{24{ld_shift[7]}},  ld_shift[7:0]};
         2'd1: ld_ext = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_ext = mem_dataout;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_ls_d  = owner_ls_q;
      we_d        = we_q;
      err_d       = err_q;
      off_d       = off_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addy_d      = addy_q;
      din_d       = din_q;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      wen_d       = 1'b0;
      ren_d       = 1'b0;
      bsel_d      = 4'h0;
      if_rvalid_d = 1'b0;
      if_rdata_d  = 32'h0;
      ls_rvalid_d = 1'b0;
      ls_rdata_d  = 32'h0;
      ls_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!if_req || if_win) begin
               cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (if_req || ls_req) begin
               state_d = ISSUE;
               if (if_win) begin
                  owner_ls_d = 1'b0;
                  if_gnt_d   = 1'b1;
                  ren_d      = 1'b1;
                  bsel_d     = 4'hF;
                  addy_d     = {2'b00, if_addr[31:2]};
                  din_d      = 32'h0;
               end else begin
                  owner_ls_d = 1'b1;
                  ls_gnt_d   = 1'b1;
                  we_d       = ls_we;
                  err_d      = ls_bad;
                  off_d      = ls_addr[1:0];
                  size_d     = ls_size;
                  uns_d      = ls_unsigned;
                  wen_d      = ls_we && !ls_bad;
                  ren_d      = !ls_we && !ls_bad;
                  bsel_d     = ls_bad ? 4'h0 : ls_bsel;
                  addy_d     = {2'b00, ls_addr[31:2]};
                  din_d      = ls_repl;
               end
            end
         end
         ISSUE: begin
            state_d = IDLE;
            if (owner_ls_q) begin
               ls_rvalid_d = 1'b1;
               ls_err_d    = err_q;
               ls_rdata_d  = (err_q || we_q) ? 32'h0 : ld_ext;
            end else begin
               if_rvalid_d = 1'b1;
               if_rdata_d  = mem_dataout;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         owner_ls_q  <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         off_q       <= 2'b00;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addy_q      <= 32'h0;
         din_q       <= 32'h0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         bsel_q      <= 4'h0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         ls_rvalid_q <= 1'b0;
         ls_rdata_q  <= 32'h0;
         ls_err_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         owner_ls_q  <= owner_ls_d;
         we_q        <= we_d;
         err_q       <= err_d;
         off_q       <= off_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addy_q      <= addy_d;
         din_q       <= din_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         wen_q       <= wen_d;
         ren_q       <= ren_d;
         bsel_q      <= bsel_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rvalid_q <= ls_rvalid_d;
         ls_rdata_q  <= ls_rdata_d;
         ls_err_q    <= ls_err_d;
      end
   end

   assign if_gnt            = if_gnt_q;
   assign if_rvalid         = if_rvalid_q;
   assign if_rdata          = if_rdata_q;
   assign ls_gnt            = ls_gnt_q;
   assign ls_rvalid         = ls_rvalid_q;
   assign ls_rdata          = ls_rdata_q;
   assign ls_err            = ls_err_q;
   assign mem_addy          = addy_q;
   assign mem_datain        = din_q;
   assign mem_wen           = wen_q;
   assign mem_ren           = ren_q;
   assign mem_byte_selector = bsel_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with a falling-edge memory.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req, ls_we, ls_unsigned;
   logic [31:0] ls_addr, ls_wdata;
   logic [1:0]  ls_size;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic [31:0] ls_rdata;
   logic [31:0] mem_addy, mem_datain;
   logic        mem_wen, mem_ren;
   logic [3:0]  mem_byte_selector;
   logic [31:0] mem_dataout;

   logic [31:0] mem [0:1023];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_LIMIT(1024), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
      .ls_unsigned(ls_unsigned), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_addy(mem_addy), .mem_datain(mem_datain), .mem_wen(mem_wen),
      .mem_ren(mem_ren), .mem_byte_selector(mem_byte_selector),
      .mem_dataout(mem_dataout)
   );

   // Memory model: acts on the falling edge, out-of-range reads return 0.
   always @(negedge clk) begin
      if (mem_ren) mem_dataout <= (mem_addy < 32'd1024) ? mem[mem_addy[9:0]] : 32'h0;
      if (mem_wen && mem_addy < 32'd1024) begin
         for (int b = 0; b < 4; b++)
            if (mem_byte_selector[b]) mem[mem_addy[9:0]][8*b +: 8] <= mem_datain[8*b +: 8];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] any_out();
      return {31'h0, |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                       mem_addy, mem_datain, mem_wen, mem_ren, mem_byte_selector}};
   endfunction

   task automatic ls_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [3:0] ebsel, input logic [31:0] eaddy,
                        input logic [31:0] edin, input logic [31:0] erdata, input logic eerr);
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_size = size;
      ls_unsigned = uns; ls_wdata = wdata;
      tick();
      chk({tag, "_gnt"}, {31'h0, ls_gnt}, 32'h1);
      chk({tag, "_wen_ren"}, {30'h0, mem_wen, mem_ren},
          eerr ? 32'h0 : (we ? 32'h2 : 32'h1));
      if (!eerr) begin
         chk({tag, "_bsel"}, {28'h0, mem_byte_selector}, {28'h0, ebsel});
         chk({tag, "_addy"}, mem_addy, eaddy);
         if (we) chk({tag, "_din"}, mem_datain, edin);
      end
      ls_req = 1'b0;
      tick();
      chk({tag, "_rvalid"}, {31'h0, ls_rvalid}, 32'h1);
      chk({tag, "_rdata"}, ls_rdata, erdata);
      chk({tag, "_err"}, {31'h0, ls_err}, {31'h0, eerr});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;
      mem_dataout = 32'h0;
      reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_size = 2'd0;
      ls_unsigned = 1'b0; ls_wdata = 32'h0;
      repeat (3) tick();
      chk("reset_outputs", any_out(), 32'h0);
      reset = 1'b0;

      // IF word read of 0x10
      if_req = 1'b1; if_addr = 32'h10;
      tick();
      chk("if_gnt", {31'h0, if_gnt}, 32'h1);
      chk("if_ren", {30'h0, mem_wen, mem_ren}, 32'h1);
      chk("if_addy", mem_addy, 32'h4);
      chk("if_bsel", {28'h0, mem_byte_selector}, 32'hF);
      if_req = 1'b0;
      tick();
      chk("if_rvalid", {31'h0, if_rvalid}, 32'h1);
      chk("if_rdata", if_rdata, 32'hDEADBEEF);
      chk("if_idle_ren", {31'h0, mem_ren}, 32'h0);

      mem[4] = 32'h80FF0011;
      ls_op("lb_s13", 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 4'b1000, 32'h4, 32'h0, 32'hFFFFFF80, 1'b0);
      ls_op("lbu_13", 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 4'b1000, 32'h4, 32'h0, 32'h00000080, 1'b0);
      ls_op("lh_s12", 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 4'b1100, 32'h4, 32'h0, 32'hFFFF80FF, 1'b0);
      ls_op("lhu_10", 1'b0, 32'h10, 2'd1, 1'b1, 32'h0, 4'b0011, 32'h4, 32'h0, 32'h00000011, 1'b0);
      ls_op("sh_0a",  1'b1, 32'h0A, 2'd1, 1'b0, 32'h1234ABCD, 4'b1100, 32'h2, 32'hABCDABCD, 32'h0, 1'b0);
      ls_op("sb_09",  1'b1, 32'h09, 2'd0, 1'b0, 32'h0000005A, 4'b0010, 32'h2, 32'h5A5A5A5A, 32'h0, 1'b0);
      ls_op("lw_08",  1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 4'hF, 32'h2, 32'h0, 32'hABCD5A00, 1'b0);
      ls_op("lw_mis", 1'b0, 32'h06, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      ls_op("sw_oor", 1'b1, 32'h1000, 2'd2, 1'b0, 32'h55AA55AA, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      ls_op("lh_mis", 1'b0, 32'h01, 2'd1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      ls_op("sz3",    1'b0, 32'h00, 2'd3, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      // Both requesters held: LS x4 then IF, grants every other cycle
      if_req = 1'b1; if_addr = 32'h10;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0; ls_size = 2'd2; ls_unsigned = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         logic [31:0] exp_g;
         tick();
         if (c % 2 == 0) exp_g = 32'h0;
         else if (((c + 1) / 2) % 5 == 0) exp_g = 32'h2;
         else exp_g = 32'h1;
         chk($sformatf("starve_c%0d", c), {30'h0, if_gnt, ls_gnt}, exp_g);
      end
      if_req = 1'b0; ls_req = 1'b0;
      tick();

      // Reset in the middle of an LS load's ISSUE cycle
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10; ls_size = 2'd2;
      tick();
      chk("rstmid_gnt", {31'h0, ls_gnt}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid_outputs", any_out(), 32'h0);
      ls_req = 1'b0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("rstmid_norvalid%0d", c), {31'h0, ls_rvalid}, 32'h0);
      end
      ls_op("post_rst_lw", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 4'hF, 32'h4, 32'h0, 32'h80FF0011, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between the instruction-fetch port (IF) and the load/store port (LS), one access at a time.
- On the LS path it also:
  - generates the memory byte-lane selects;
  - replicates store data across lanes;
  - aligns and sign- or zero-extends load data;
  - detects misaligned and out-of-range accesses.
- Sits between the core pipeline and the memory block; the memory acts on the falling edge.

Parameters:
- ADDR_LIMIT, 1024: number of 32-bit words in the memory. A word index of ADDR_LIMIT or more is out of range.
- STARVE_MAX, 4: number of consecutive arbitrations IF may lose before it is forced to win.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr until if_gnt.
- if_addr  in  32  IF byte address; bits [1:0] ignored.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- ls_req  in  1  LS request; held with all ls_* inputs until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  LS byte address.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as misaligned.
- ls_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- ls_wdata  in  32  store data, right-justified.
- ls_gnt  out  1  one-cycle pulse: LS request accepted.
- ls_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- ls_rdata  out  32  extended load data; 0 for stores and errors.
- ls_err  out  1  pulses with ls_rvalid on a misaligned or out-of-range access.
- mem_addy  out  32  word index, {2'b0, addr[31:2]}.
- mem_datain  out  32  lane-replicated store data.
- mem_wen  out  1  memory write enable.
- mem_ren  out  1  memory read enable.
- mem_byte_selector  out  4  byte-lane enables; bit n = bits [8n+7:8n].
- mem_dataout  in  32  memory read data, stable by the rising edge following the command.

Behaviour:
- Reset (asynchronous):
  - state is IDLE and the starvation counter is 0;
  - every output is 0;
  - an in-flight access is discarded and produces no rvalid.
- FSM has two states, IDLE and ISSUE.
- IDLE, at a rising edge with any request pending:
  - pick the winner;
  - register the command;
  - pulse the winner's gnt for the next cycle;
  - go to ISSUE.
- ISSUE:
  - mem_* outputs are driven from the command registers for exactly this cycle;
  - no arbitration takes place;
  - at the next rising edge, capture mem_dataout, pulse the winner's rvalid together with rdata (and err) for one cycle, and return to IDLE.
- Timing:
  - latency is request sampled at edge k → gnt and memory command during cycle k+1 → rvalid during cycle k+2;
  - because arbitration runs again at edge k+2, the maximum throughput is one access every 2 cycles.
- Outside ISSUE: mem_wen, mem_ren and mem_byte_selector are 0. mem_wen and mem_ren are never both 1.
- Arbitration:
  - LS wins by default;
  - IF wins if the starvation counter equals STARVE_MAX;
  - the counter increments when IF is pending and loses, and clears when IF wins or if_req is low;
  - the counter saturates at STARVE_MAX.
- IF access:
  - always a word read, with mem_byte_selector = 4'hF;
  - never errors;
  - out-of-range addresses are passed to the memory, which returns 0.
- LS alignment, with o = ls_addr[1:0]:
  - byte is always aligned;
  - half needs o[0] = 0;
  - word needs o = 0.
- LS out of range: ls_addr[31:2] ≥ ADDR_LIMIT.
- LS error (misaligned or out of range):
  - ISSUE runs with mem_wen = mem_ren = 0;
  - ls_rvalid and ls_err pulse together, with ls_rdata = 0.
- Byte selects:
  - byte: 4'b0001 << o;
  - half: 4'b0011 << o;
  - word: 4'hF.
- Store data replication:
  - byte: {4{ls_wdata[7:0]}};
  - half: {2{ls_wdata[15:0]}};
  - word: ls_wdata.
- Load data, taken from lane o:
  - byte uses mem_dataout[8o+7:8o], half uses [8o+15:8o];
  - the lane is extended to 32 bits per ls_unsigned;
  - a word is passed through unchanged.
- A store completes with ls_rvalid = 1, ls_rdata = 0, ls_err = 0.
- Requests held during ISSUE are evaluated at the ISSUE→IDLE edge. A requester must not drop req before gnt.

Test Plan:
- Reset, then an IF read of 0x10 where memory word 4 = 0xDEADBEEF → if_gnt in cycle 1, mem_ren = 1, mem_addy = 4, mem_byte_selector = F in cycle 1, if_rvalid = 1 with if_rdata = 0xDEADBEEF in cycle 2.
- LS signed byte load at 0x13, word 4 = 0x80FF0011 → selector 4'b1000, ls_rdata = 0xFFFFFF80. The same load unsigned → 0x00000080. A signed half load at 0x12 → 0xFFFF80FF.
- LS half store of 0x1234ABCD at 0x0A → mem_wen = 1, mem_addy = 2, selector 4'b1100, mem_datain = 0xABCDABCD; ls_rvalid = 1, ls_rdata = 0.
- Word load at 0x06 → no mem_ren/mem_wen in ISSUE; ls_rvalid = ls_err = 1, ls_rdata = 0. Word store at 0x1000 (index 1024) → likewise, ls_err = 1.
- if_req and ls_req held high continuously → grant order LS×4, IF, LS×4, IF...; every grant is separated by exactly 2 cycles.
- Reset asserted mid-ISSUE of an LS load → all outputs 0 immediately; no ls_rvalid after reset is released; the next request is served normally.
